// File: rtl/cache_ram_pkg.sv
// Shared types and helpers for the multi-way cache data RAM.
package cache_ram_pkg;

  typedef enum logic [0:0] {
    INIT,
    READY
  } cache_ram_state_e;

  function automatic int unsigned bytes_per_word(input int unsigned len_data);
    return len_data / 8;
  endfunction

endpackage

// File: rtl/cache_ram_bank.sv
// Single-way byte-enabled simple dual-port RAM with a registered read port.
// The array is never reset; the owner is responsible for clearing it.
module cache_ram_bank
  import cache_ram_pkg::*;
#(
  parameter int unsigned LEN_DATA = 32,
  parameter int unsigned LEN_ADDR = 7
) (
  input  logic                               clk,
  input  logic [bytes_per_word(LEN_DATA)-1:0] we,
  input  logic [LEN_ADDR-1:0]                waddr,
  input  logic [LEN_DATA-1:0]                wdata,
  input  logic                               re,
  input  logic [LEN_ADDR-1:0]                raddr,
  output logic [LEN_DATA-1:0]                rdata
);

  localparam int unsigned NB    = bytes_per_word(LEN_DATA);
  localparam int unsigned DEPTH = 2 ** LEN_ADDR;

  logic [LEN_DATA-1:0] mem [DEPTH];
  logic [LEN_DATA-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // Read-first: a same-cycle write to raddr is not visible here.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cache_way_ram.sv
// Multi-way cache data RAM with self-clear after reset.
// Define CACHE_RAM_BYPASS_EN to forward same-cycle same-set write bytes to the read.
module cache_way_ram
  import cache_ram_pkg::*;
#(
  parameter int unsigned LEN_DATA = 32,
  parameter int unsigned LEN_ADDR = 7,
  parameter int unsigned NUM_WAYS = 2
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           ena,
  input  logic [NUM_WAYS*LEN_DATA/8-1:0] wea,
  input  logic [LEN_ADDR-1:0]            addra,
  input  logic [LEN_DATA-1:0]            dina,
  input  logic                           enb,
  input  logic [LEN_ADDR-1:0]            addrb,
  output logic [NUM_WAYS*LEN_DATA-1:0]   doutb,
  output logic                           rvalid,
  output logic                           init_busy
);

  localparam int unsigned NB    = bytes_per_word(LEN_DATA);
  localparam int unsigned DEPTH = 2 ** LEN_ADDR;
  localparam logic [LEN_ADDR:0] LAST_SET = (LEN_ADDR + 1)'(DEPTH - 1);

  cache_ram_state_e state_q, state_d;
  logic [LEN_ADDR:0] cnt_q, cnt_d;
  logic rvalid_q;
  logic clr_q;  // holds doutb at zero until the first read after reset

  logic                         ready;
  logic [NUM_WAYS*NB-1:0]       bank_we;
  logic [LEN_ADDR-1:0]          bank_waddr;
  logic [LEN_DATA-1:0]          bank_wdata;
  logic                         bank_re;
  logic [NUM_WAYS*LEN_DATA-1:0] bank_rdata;
  logic [NUM_WAYS*LEN_DATA-1:0] merged;

  assign ready      = (state_q == READY);
  assign bank_we    = ready ? (ena ? wea : '0) : '1;
  assign bank_waddr = ready ? addra : cnt_q[LEN_ADDR-1:0];
  assign bank_wdata = ready ? dina : '0;
  assign bank_re    = ready & enb;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) state_d = READY;
      end
      READY: ;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      clr_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= bank_re;
      if (bank_re) clr_q <= 1'b0;
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    cache_ram_bank #(
      .LEN_DATA (LEN_DATA),
      .LEN_ADDR (LEN_ADDR)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[w*NB +: NB]),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .re    (bank_re),
      .raddr (addrb),
      .rdata (bank_rdata[w*LEN_DATA +: LEN_DATA])
    );
  end

`ifdef CACHE_RAM_BYPASS_EN
  logic [NUM_WAYS*NB-1:0] byp_mask_q;
  logic [LEN_DATA-1:0]    byp_data_q;

  // Captured only on an accepted read so the merged output holds with doutb.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else if (bank_re) begin
      byp_mask_q <= (addra == addrb) ? bank_we : '0;
      byp_data_q <= dina;
    end
  end

  always_comb begin
    merged = bank_rdata;
    for (int w = 0; w < NUM_WAYS; w++) begin
      for (int b = 0; b < NB; b++) begin
        if (byp_mask_q[w*NB+b]) merged[w*LEN_DATA+b*8 +: 8] = byp_data_q[b*8 +: 8];
      end
    end
  end
`else
  assign merged = bank_rdata;
`endif

  assign doutb     = clr_q ? '0 : merged;
  assign rvalid    = rvalid_q;
  assign init_busy = (state_q == INIT);

endmodule

// File: tb/tb_cache_way_ram.sv
// Self-checking bench for cache_way_ram (default parameters, 2 ways x 32 bits x 128 sets).
module tb_cache_way_ram;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ena = 1'b0;
  logic [7:0]  wea = '0;
  logic [6:0]  addra = '0;
  logic [31:0] dina = '0;
  logic        enb = 1'b0;
  logic [6:0]  addrb = '0;
  logic [63:0] doutb;
  logic        rvalid;
  logic        init_busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [2][DEPTH];
  logic [63:0] sb_q[$];
  logic        bench_ready = 1'b0;

  cache_way_ram dut (
    .clk       (clk),
    .resetn    (resetn),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .enb       (enb),
    .addrb     (addrb),
    .doutb     (doutb),
    .rvalid    (rvalid),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  task automatic clear_model();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < DEPTH; s++) model[w][s] = '0;
    sb_q.delete();
  endtask

  // Drive one cycle of requests; expected read data goes to the scoreboard.
  task automatic step(input logic e_a, input logic [7:0] w_a, input logic [6:0] a_a,
                      input logic [31:0] d_a, input logic e_b, input logic [6:0] a_b);
    logic [63:0] pre, post;
    ena = e_a; wea = w_a; addra = a_a; dina = d_a; enb = e_b; addrb = a_b;
    if (bench_ready) begin
      pre = {model[1][a_b], model[0][a_b]};
      if (e_a)
        for (int w = 0; w < 2; w++)
          for (int b = 0; b < 4; b++)
            if (w_a[w*4+b]) model[w][a_a][b*8 +: 8] = d_a[b*8 +: 8];
      post = {model[1][a_b], model[0][a_b]};
`ifdef CACHE_RAM_BYPASS_EN
      if (e_b) sb_q.push_back(post);
`else
      if (e_b) sb_q.push_back(pre);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 7'd0, 32'h0, 1'b0, 7'd0);
  endtask

  // Counts init_busy cycles from now, bounded.
  task automatic wait_init(output int n);
    n = 0;
    while (init_busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    bench_ready = !init_busy;
  endtask

  task automatic check_read(input string name);
    logic [63:0] exp;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    checks++;
    if (rvalid !== 1'b1 || doutb !== exp) begin
      errors++;
      $display("FAIL %s: rvalid=%b doutb=%h, required rvalid=1 doutb=%h", name, rvalid, doutb, exp);
    end
  endtask

  task automatic test_reset();
    int n;
    resetn = 1'b0;
    bench_ready = 1'b0;
    clear_model();
    #1;
    checks++;
    if (init_busy !== 1'b1 || rvalid !== 1'b0 || doutb !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: init_busy=%b rvalid=%b doutb=%h, required 1 0 0",
               init_busy, rvalid, doutb);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_init(n);
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL init_length: busy cycles=%0d, required %0d", n, DEPTH);
    end
  endtask

  task automatic test_clear_read();
    step(1'b0, 8'h00, 7'd0, 32'h0, 1'b1, 7'd0);
    check_read("clear_set0");
    step(1'b0, 8'h00, 7'd0, 32'h0, 1'b1, 7'd127);
    check_read("clear_set127");
  endtask

  task automatic test_byte_write();
    step(1'b1, 8'b0101_0000, 7'd5, 32'hAABBCCDD, 1'b0, 7'd0);
    step(1'b0, 8'h00, 7'd0, 32'h0, 1'b1, 7'd5);
    checks++;
    if (doutb !== {32'h00BB00DD, 32'h0}) begin
      errors++;
      $display("FAIL byte_write: doutb=%h, required %h", doutb, {32'h00BB00DD, 32'h0});
    end
    check_read("byte_write_sb");
    // Enable with no byte lanes must not disturb the set.
    step(1'b1, 8'h00, 7'd5, 32'hFFFFFFFF, 1'b0, 7'd0);
    step(1'b0, 8'h00, 7'd0, 32'h0, 1'b1, 7'd5);
    check_read("noop_write");
  endtask

  task automatic test_same_addr();
    logic [63:0] req;
    step(1'b1, 8'hFF, 7'd9, 32'h11111111, 1'b0, 7'd0);
    step(1'b1, 8'hFF, 7'd9, 32'h22222222, 1'b1, 7'd9);
`ifdef CACHE_RAM_BYPASS_EN
    req = {2{32'h22222222}};
`else
    req = {2{32'h11111111}};
`endif
    checks++;
    if (doutb !== req) begin
      errors++;
      $display("FAIL same_addr: doutb=%h, required %h", doutb, req);
    end
    check_read("same_addr_sb");
    // Partial-byte collision on one way only.
    step(1'b1, 8'b0000_0011, 7'd9, 32'h3344_5566, 1'b1, 7'd9);
    check_read("same_addr_partial");
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'hFF, 7'd0, 32'hA0A0A0A0, 1'b0, 7'd0);
    step(1'b1, 8'h0F, 7'd1, 32'hB1B1B1B1, 1'b0, 7'd0);
    step(1'b1, 8'hF0, 7'd2, 32'hC2C2C2C2, 1'b0, 7'd0);
    step(1'b0, 8'h00, 7'd0, 32'h0, 1'b1, 7'd0);
    check_read("b2b_set0");
    step(1'b0, 8'h00, 7'd0, 32'h0, 1'b1, 7'd1);
    check_read("b2b_set1");
    step(1'b0, 8'h00, 7'd0, 32'h0, 1'b1, 7'd2);
    check_read("b2b_set2");
    idle();
    checks++;
    if (rvalid !== 1'b0 || doutb !== {32'hC2C2C2C2, 32'h0}) begin
      errors++;
      $display("FAIL b2b_hold: rvalid=%b doutb=%h, required 0 %h", rvalid, doutb,
               {32'hC2C2C2C2, 32'h0});
    end
    // Independent read and write on different sets in one cycle.
    step(1'b1, 8'hFF, 7'd20, 32'h5A5A5A5A, 1'b1, 7'd1);
    check_read("rw_diff_read");
    step(1'b0, 8'h00, 7'd0, 32'h0, 1'b1, 7'd20);
    check_read("rw_diff_written");
  endtask

  task automatic test_reset_mid_init();
    int n;
    resetn = 1'b0;
    bench_ready = 1'b0;
    clear_model();
    #2;
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) idle();
    resetn = 1'b0;
    #1;
    checks++;
    if (init_busy !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_init_reset: init_busy=%b rvalid=%b, required 1 0", init_busy, rvalid);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    // Requests during the clear must be ignored.
    for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, 7'd7, 32'hDEADBEEF, 1'b1, 7'd7);
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL init_rvalid: rvalid=%b, required 0", rvalid);
    end
    wait_init(n);
    checks++;
    if (n + 5 !== DEPTH) begin
      errors++;
      $display("FAIL mid_init_length: busy cycles=%0d, required %0d", n + 5, DEPTH);
    end
    step(1'b0, 8'h00, 7'd0, 32'h0, 1'b1, 7'd7);
    check_read("init_write_ignored");
  endtask

  task automatic test_reset_ready();
    int n;
    step(1'b1, 8'hFF, 7'd3, 32'h87654321, 1'b0, 7'd0);
    step(1'b0, 8'h00, 7'd0, 32'h0, 1'b1, 7'd3);
    check_read("ready_set3");
    resetn = 1'b0;
    bench_ready = 1'b0;
    clear_model();
    #1;
    checks++;
    if (doutb !== 64'h0 || rvalid !== 1'b0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL ready_reset: doutb=%h rvalid=%b init_busy=%b, required 0 0 1",
               doutb, rvalid, init_busy);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_init(n);
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL ready_reset_length: busy cycles=%0d, required %0d", n, DEPTH);
    end
    step(1'b0, 8'h00, 7'd0, 32'h0, 1'b1, 7'd3);
    check_read("set3_cleared");
  endtask

  initial begin
    test_reset();
    test_clear_read();
    test_byte_write();
    test_same_addr();
    test_back_to_back();
    test_reset_mid_init();
    test_reset_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
